// File: rtl/bus_txn_initiator.sv
// Controller-side bus transaction initiator: header, handoff, beat count, ack.
// Optional DATA-phase idle timeout enabled by defining BUS_TIMEOUT_EN.
module bus_txn_initiator #(
  parameter int          LEN_W       = 8,
  parameter int          HANDOFF_CYC = 3,
  parameter logic [1:0]  CTRL_ID     = 2'b11,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_src,
  input  logic [1:0]       req_dst,
  input  logic [1:0]       req_op,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ack,
  inout  wire  [7:0]       bus_data,
  inout  wire              bus_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HANDOFF,
    S_DATA,
    S_ACK
  } state_e;

  localparam int HW = (HANDOFF_CYC > 1) ? $clog2(HANDOFF_CYC) : 1;

  state_e           state_q, state_d;
  logic [7:0]       hdr_q, hdr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic             sticky_q, sticky_d;
  logic             drive_q, drive_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             beat;
  logic             tmo;

`ifdef BUS_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_q, idle_d;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYC;
`endif

  // Our own header drive must never count as a beat.
  assign beat   = (bus_valid == 1'b1) && !drive_q;
  assign accept = req_valid && rdy_q;

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    sticky_d = sticky_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmo      = 1'b0;
`ifdef BUS_TIMEOUT_EN
    idle_d   = idle_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          hdr_d = {req_op, req_dst, req_src, CTRL_ID};
          len_d = req_len;
          if (req_src == CTRL_ID || req_src == req_dst) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        state_d = S_HANDOFF;
        hcnt_d  = '0;
      end
      S_HANDOFF: begin
        if (beat) sticky_d = 1'b1;
        if (hcnt_q == HW'(HANDOFF_CYC - 1)) begin
          state_d = (len_q == '0) ? S_ACK : S_DATA;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (beat) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = S_ACK;
`ifdef BUS_TIMEOUT_EN
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_d == IW'(TIMEOUT_CYC)) begin
            state_d = S_ACK;
            tmo     = 1'b1;
          end
`endif
        end
      end
      S_ACK: begin
        state_d  = S_IDLE;
        sticky_d = 1'b0;
        cnt_d    = '0;
`ifdef BUS_TIMEOUT_EN
        idle_d   = '0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ACK && state_q != S_ACK) begin
      ack_d  = 1'b1;
      done_d = 1'b1;
      err_d  = sticky_d | tmo;
    end
    drive_d = (state_d == S_HDR);
    rdy_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hdr_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      sticky_q <= 1'b0;
      drive_q  <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      idle_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      sticky_q <= sticky_d;
      drive_q  <= drive_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
`ifdef BUS_TIMEOUT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign bus_data  = drive_q ? hdr_q : 8'bz;
  assign bus_valid = drive_q ? 1'b1 : 1'bz;
  assign req_ready = rdy_q;
  assign busy      = (state_q != S_IDLE);
  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
